// File: rtl/seq_chunk_adder_if.sv
// Handshake and operand bus for seq_chunk_adder. The subtract select i_sub
// exists only when SEQ_ADDER_SUB_EN is defined.
interface seq_chunk_adder_if #(
    parameter int WIDTH = 8
);
    logic             i_start;
    logic [WIDTH-1:0] i_add_term1;
    logic [WIDTH-1:0] i_add_term2;
`ifdef SEQ_ADDER_SUB_EN
    logic             i_sub;
`endif
    logic             o_ready;
    logic             o_valid;
    logic [WIDTH:0]   o_result;

`ifdef SEQ_ADDER_SUB_EN
    modport master (
        output i_start, i_add_term1, i_add_term2, i_sub,
        input  o_ready, o_valid, o_result
    );
    modport slave (
        input  i_start, i_add_term1, i_add_term2, i_sub,
        output o_ready, o_valid, o_result
    );
`else
    modport master (
        output i_start, i_add_term1, i_add_term2,
        input  o_ready, o_valid, o_result
    );
    modport slave (
        input  i_start, i_add_term1, i_add_term2,
        output o_ready, o_valid, o_result
    );
`endif
endinterface

// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder: CHUNK bits per clock through a registered ripple carry.
// Optional subtract mode is enabled by defining SEQ_ADDER_SUB_EN.
module seq_chunk_adder #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    seq_chunk_adder_if.slave   bus
);

    localparam int NUM_CHUNKS = WIDTH / CHUNK;
    localparam int K_W        = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [K_W-1:0] LAST_K = K_W'(NUM_CHUNKS - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    typedef logic [NUM_CHUNKS-1:0][CHUNK-1:0] chunks_t;

    state_t         state_q,  state_d;
    chunks_t        a_q,      a_d;
    chunks_t        b_q,      b_d;
    chunks_t        sum_q,    sum_d;
    logic [K_W-1:0] k_q,      k_d;
    logic           carry_q,  carry_d;
    logic [WIDTH:0] result_q, result_d;
    logic           valid_q,  valid_d;

    logic [CHUNK:0] chunk_sum;

    // b_q holds the already-inverted operand when subtracting, so RUN is a plain add.
    assign chunk_sum = {1'b0, a_q[k_q]} + {1'b0, b_q[k_q]} + (CHUNK + 1)'(carry_q);

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sum_d    = sum_q;
        k_d      = k_q;
        carry_d  = carry_q;
        result_d = result_q;
        valid_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.i_start) begin
                    a_d     = bus.i_add_term1;
                    sum_d   = '0;
                    k_d     = '0;
`ifdef SEQ_ADDER_SUB_EN
                    b_d     = bus.i_sub ? ~bus.i_add_term2 : bus.i_add_term2;
                    carry_d = bus.i_sub;
`else
                    b_d     = bus.i_add_term2;
                    carry_d = 1'b0;
`endif
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[k_q] = chunk_sum[CHUNK-1:0];
                carry_d    = chunk_sum[CHUNK];
                if (k_q == LAST_K) begin
                    result_d = {chunk_sum[CHUNK], sum_d};
                    valid_d  = 1'b1;
                    state_d  = DONE;
                end else begin
                    k_d = k_q + K_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sum_q    <= '0;
            k_q      <= '0;
            carry_q  <= 1'b0;
            result_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sum_q    <= sum_d;
            k_q      <= k_d;
            carry_q  <= carry_d;
            result_q <= result_d;
            valid_q  <= valid_d;
        end
    end

    assign bus.o_ready  = (state_q == IDLE);
    assign bus.o_valid  = valid_q;
    assign bus.o_result = result_q;

endmodule
